// File: rtl/serial_shifter_pkg.sv
// ==== shift_pkg: shared mode encoding and amount helpers for serial_shifter ====
// Rev 1.0
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROR = 2'b11
  } shift_mode_e;

  function automatic int amt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  // Linear shifts saturate at width; rotates wrap because a full turn is identity.
  function automatic int eff_amt(input int amt, input shift_mode_e mode, input int width);
    if (mode == ROR) return amt % width;
    return (amt > width) ? width : amt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_shifter_if.sv
// ==== serial_shifter_if: operand/result valid-ready handshakes plus status ====
// Rev 1.0
`default_nettype none

interface serial_shifter_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = $clog2(WIDTH) + 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AMT_W-1:0] in_amt;
  logic [1:0]       in_mode;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_signed, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_signed, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

`default_nettype wire

// File: rtl/serial_shifter_step.sv
// ==== shift_step: one combinational shift of up to STEP bits ====
// Rev 1.0
`default_nettype none

module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int K_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic [K_W-1:0]   i_k,
  input  shift_mode_e      i_mode,
  input  logic             i_sign,
  output logic [WIDTH-1:0] o_data
);

  logic w_fill;

  // The MSB never changes under a sign-filling shift, so it stays the latched sign.
  assign w_fill = (i_mode == SRA) && i_sign && i_data[WIDTH-1];

  always_comb begin
    o_data = i_data;
    unique case (i_mode)
      SLL:      o_data = i_data << i_k;
      SRL, SRA: o_data = WIDTH'({{WIDTH{w_fill}}, i_data} >> i_k);
      ROR:      o_data = WIDTH'({i_data, i_data} >> i_k);
      default:  o_data = i_data;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/serial_shifter.sv
// ==== serial_shifter: multi-cycle SLL/SRL/SRA/ROR unit, STEP bits per clock ====
// Rev 1.0
`default_nettype none

module serial_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int AMT_W = amt_width(WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  serial_shifter_if.slave bus
);

  localparam int K_W = $clog2(STEP + 1);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("serial_shifter: WIDTH must be a power of two >= 2");
  end
  if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
    $error("serial_shifter: STEP must be in 1..WIDTH");
  end
  if (AMT_W != amt_width(WIDTH)) begin : g_bad_amt_w
    $error("serial_shifter: AMT_W is derived and must not be overridden");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           r_state;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_golden;
  logic [AMT_W-1:0] r_rem;
  shift_mode_e      r_mode;
  logic             r_sign;
  logic             r_out_valid;

  shift_mode_e      w_in_mode;
  logic [AMT_W-1:0] w_eff;
  logic [AMT_W-1:0] w_k_full;
  logic [K_W-1:0]   w_k;
  logic [WIDTH-1:0] w_step_data;
  logic [WIDTH-1:0] w_golden;

  assign w_in_mode = shift_mode_e'(bus.in_mode);
  assign w_eff     = AMT_W'(eff_amt(int'(bus.in_amt), w_in_mode, WIDTH));
  assign w_k_full  = (r_rem > AMT_W'(STEP)) ? AMT_W'(STEP) : r_rem;
  assign w_k       = K_W'(w_k_full);

  assign bus.in_ready  = (r_state == S_IDLE) && !reset;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_data;
  assign bus.busy      = (r_state != S_IDLE);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .K_W   (K_W)
  ) u_step (
    .i_data (r_data),
    .i_k    (w_k),
    .i_mode (r_mode),
    .i_sign (r_sign),
    .o_data (w_step_data)
  );

  // Single-cycle reference result, captured at accept and held for the check.
  always_comb begin
    w_golden = '0;
    unique case (w_in_mode)
      SLL: w_golden = bus.in_data << bus.in_amt;
      SRL: w_golden = bus.in_data >> bus.in_amt;
      SRA: begin
        if (bus.in_signed) w_golden = $signed(bus.in_data) >>> bus.in_amt;
        else               w_golden = $unsigned(bus.in_data) >>> bus.in_amt;
      end
      ROR: w_golden = WIDTH'({bus.in_data, bus.in_data} >> bus.in_amt[AMT_W-2:0]);
      default: w_golden = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_golden    <= '0;
      r_rem       <= '0;
      r_mode      <= SLL;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_data   <= bus.in_data;
            r_mode   <= w_in_mode;
            r_sign   <= bus.in_signed;
            r_golden <= w_golden;
            r_rem    <= w_eff;
            if (w_eff == '0) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_data <= w_step_data;
          r_rem  <= r_rem - w_k_full;
          if (r_rem == w_k_full) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  a_golden: assert property (@(posedge clk) disable iff (reset)
    r_out_valid |-> (r_data == r_golden));

endmodule

`default_nettype wire
